multicycle_controller: RTL

- Multi-cycle sequencer for the 32-bit MIPS core.
- Steps each instruction through FETCH/DECODE/EXECUTE/MEM/WB and drives the shared ALU's opcode/ALU_control selects, PC/IR write strobes, memory handshake and register-file write controls.
- Uses the ALU's sig_branch to resolve beq/bne.
- Holds retired-instruction and cycle counters, and a memory-timeout watchdog that halts the core on a bus hang.

---
 rtl/multicycle_controller_if.sv | 44 ++++
 rtl/multicycle_controller.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/multicycle_controller_if.sv
// Control/status bundle between the multicycle sequencer and the MIPS datapath/memory.
interface multicycle_controller_if;
    // Memory handshake: mem_read/mem_write is a request held high while the sequencer
    // waits; a transfer completes on the rising edge where mem_ready is high together
    // with the request (ready in the same cycle as the request is allowed).
    logic [31:0] ir;
    logic        sig_branch;
    logic        mem_ready;
    logic        mem_read;
    logic        mem_write;
    logic        iord;
    logic        ir_write;
    logic        pc_write;
    logic [1:0]  pc_src;
    logic        alu_src_a;
    logic        alu_src_b;
    logic [5:0]  alu_opcode;
    logic [5:0]  alu_control;
    logic        reg_write;
    logic        reg_dst;
    logic        mem_to_reg;
    logic        instr_retired;
    logic        illegal_instr;
    logic        bus_error;
    logic [31:0] retired_count;
    logic [31:0] cycle_count;
    logic [2:0]  state;

    modport master (
        input  ir, sig_branch, mem_ready,
        output mem_read, mem_write, iord, ir_write, pc_write, pc_src,
               alu_src_a, alu_src_b, alu_opcode, alu_control,
               reg_write, reg_dst, mem_to_reg, instr_retired, illegal_instr,
               bus_error, retired_count, cycle_count, state
    );

    modport slave (
        output ir, sig_branch, mem_ready,
        input  mem_read, mem_write, iord, ir_write, pc_write, pc_src,
               alu_src_a, alu_src_b, alu_opcode, alu_control,
               reg_write, reg_dst, mem_to_reg, instr_retired, illegal_instr,
               bus_error, retired_count, cycle_count, state
    );
endinterface

// File: rtl/multicycle_controller.sv
// Multi-cycle FETCH/DECODE/EXECUTE/MEM/WB sequencer for the 32-bit MIPS core,
// with retire/cycle counters and a memory-hang watchdog that parks the core in HALT.
module multicycle_controller #(
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    multicycle_controller_if.master bus
);
    typedef enum logic [2:0] {
        FETCH   = 3'd0,
        DECODE  = 3'd1,
        EXECUTE = 3'd2,
        MEM     = 3'd3,
        WB      = 3'd4,
        HALT    = 3'd7
    } state_t;

    localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(MEM_TIMEOUT);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] wait_cnt;
    logic [31:0]      retired_q, cycles_q;
    logic             bus_error_q;

    logic [5:0] op, funct;
    logic       is_rtype, is_ialu, is_branch, is_load, is_store, is_jump, is_legal;
    logic       timed_out, halt_enter;

    logic       mem_read, mem_write, iord, ir_write, pc_write;
    logic [1:0] pc_src;
    logic       alu_src_a, alu_src_b;
    logic [5:0] alu_opcode, alu_control;
    logic       reg_write, reg_dst, mem_to_reg, retire, illegal;

    assign op    = bus.ir[31:26];
    assign funct = bus.ir[5:0];

    assign is_rtype  = (op == 6'h00) && (funct inside {6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25,
                                                       6'h27, 6'h03, 6'h02, 6'h00, 6'h2B, 6'h2A});
    assign is_ialu   = op inside {6'h08, 6'h09, 6'h0C, 6'h0D, 6'h0F, 6'h0A, 6'h0B};
    assign is_branch = op inside {6'h04, 6'h05};
    assign is_load   = op inside {6'h23, 6'h24, 6'h25, 6'h30};
    assign is_store  = op inside {6'h28, 6'h29, 6'h2B};
    assign is_jump   = (op == 6'h02);
    assign is_legal  = is_rtype | is_ialu | is_branch | is_load | is_store | is_jump;

    // mem_ready on the timeout cycle completes the access instead of halting.
    assign timed_out = (wait_cnt == TIMEOUT_VAL) && !bus.mem_ready;

    always_comb begin
        state_d     = state_q;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        iord        = 1'b0;
        ir_write    = 1'b0;
        pc_write    = 1'b0;
        pc_src      = 2'b00;
        alu_src_a   = 1'b0;
        alu_src_b   = 1'b0;
        alu_opcode  = 6'h00;
        alu_control = 6'h00;
        reg_write   = 1'b0;
        reg_dst     = 1'b0;
        mem_to_reg  = 1'b0;
        retire      = 1'b0;
        illegal     = 1'b0;
        halt_enter  = 1'b0;
        if (!reset) begin
            case (state_q)
                FETCH: begin
                    mem_read    = 1'b1;
                    alu_src_b   = 1'b1;
                    alu_control = 6'h21;
                    if (bus.mem_ready) begin
                        ir_write = 1'b1;
                        pc_write = 1'b1;
                        state_d  = DECODE;
                    end else if (timed_out) begin
                        halt_enter = 1'b1;
                        state_d    = HALT;
                    end
                end
                DECODE: begin
                    if (is_jump) begin
                        pc_write = 1'b1;
                        pc_src   = 2'b10;
                        retire   = 1'b1;
                        state_d  = FETCH;
                    end else if (!is_legal) begin
                        illegal = 1'b1;
                        state_d = FETCH;
                    end else begin
                        state_d = EXECUTE;
                    end
                end
                EXECUTE, MEM, WB: begin
                    // The ALU keeps seeing the instruction's own selects through MEM and WB.
                    alu_src_a   = 1'b1;
                    alu_opcode  = op;
                    alu_control = funct;
                    if (state_q == EXECUTE) begin
                        if (is_branch) begin
                            pc_write = bus.sig_branch;
                            pc_src   = 2'b01;
                            retire   = 1'b1;
                            state_d  = FETCH;
                        end else if (is_load || is_store) begin
                            state_d = MEM;
                        end else begin
                            state_d = WB;
                        end
                    end else if (state_q == MEM) begin
                        iord      = 1'b1;
                        mem_read  = is_load;
                        mem_write = is_store;
                        if (bus.mem_ready) begin
                            retire  = is_store;
                            state_d = is_store ? FETCH : WB;
                        end else if (timed_out) begin
                            halt_enter = 1'b1;
                            state_d    = HALT;
                        end
                    end else begin
                        reg_write  = 1'b1;
                        reg_dst    = is_rtype;
                        mem_to_reg = is_load;
                        retire     = 1'b1;
                        state_d    = FETCH;
                    end
                end
                HALT: state_d = HALT;
                default: state_d = FETCH;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= FETCH;
            wait_cnt    <= '0;
            retired_q   <= 32'd0;
            cycles_q    <= 32'd0;
            bus_error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_d != state_q)
                wait_cnt <= '0;
            else if ((state_q == FETCH || state_q == MEM) && !bus.mem_ready)
                wait_cnt <= wait_cnt + 1'b1;
            if (retire)
                retired_q <= retired_q + 32'd1;
            if (state_q != HALT)
                cycles_q <= cycles_q + 32'd1;
            if (halt_enter)
                bus_error_q <= 1'b1;
        end
    end

    assign bus.mem_read      = mem_read;
    assign bus.mem_write     = mem_write;
    assign bus.iord          = iord;
    assign bus.ir_write      = ir_write;
    assign bus.pc_write      = pc_write;
    assign bus.pc_src        = pc_src;
    assign bus.alu_src_a     = alu_src_a;
    assign bus.alu_src_b     = alu_src_b;
    assign bus.alu_opcode    = alu_opcode;
    assign bus.alu_control   = alu_control;
    assign bus.reg_write     = reg_write;
    assign bus.reg_dst       = reg_dst;
    assign bus.mem_to_reg    = mem_to_reg;
    assign bus.instr_retired = retire;
    assign bus.illegal_instr = illegal;
    assign bus.bus_error     = bus_error_q;
    assign bus.retired_count = retired_q;
    assign bus.cycle_count   = cycles_q;
    assign bus.state         = state_q;
endmodule
